// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle CPU control FSM
package ctrl_pkg;

   localparam int ST_W = 4;

   typedef enum logic [ST_W-1:0] {
      RST    = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      EXEC   = 4'd3,
      MEM_RD = 4'd4,
      MEM_WR = 4'd5,
      WB_ALU = 4'd6,
      WB_MEM = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      RTYPE = 3'd0,
      ADDI  = 3'd1,
      LW    = 3'd2,
      SW    = 3'd3,
      BEQ   = 3'd4,
      J     = 3'd5,
      ILL   = 3'd6
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_AND = 3'd1;
   localparam logic [2:0] ALU_OR  = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction class and B-operand mux decode
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   output iclass_t        cls,
   output logic [2:0]     alu_op,
   output logic           b_sel_pos,
   output logic           b_sel_neg,
   output logic           alu_cin
);

   // Classify the instruction; subtracting forms select complemented B with carry-in
   always_comb begin
      cls       = ILL;
      alu_op    = ALU_ADD;
      b_sel_pos = 1'b1;
      b_sel_neg = 1'b0;
      alu_cin   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: cls = RTYPE;
               FN_SUB: begin
                  cls       = RTYPE;
                  b_sel_pos = 1'b0;
                  b_sel_neg = 1'b1;
                  alu_cin   = 1'b1;
               end
               FN_AND: begin
                  cls    = RTYPE;
                  alu_op = ALU_AND;
               end
               FN_OR: begin
                  cls    = RTYPE;
                  alu_op = ALU_OR;
               end
               FN_SLT: begin
                  cls       = RTYPE;
                  alu_op    = ALU_SLT;
                  b_sel_pos = 1'b0;
                  b_sel_neg = 1'b1;
                  alu_cin   = 1'b1;
               end
               default: cls = ILL;
            endcase
         end
         OP_ADDI: cls = ADDI;
         OP_LW:   cls = LW;
         OP_SW:   cls = SW;
         OP_BEQ: begin
            cls       = BEQ;
            b_sel_pos = 1'b0;
            b_sel_neg = 1'b1;
            alu_cin   = 1'b1;
         end
         OP_J:    cls = J;
         default: cls = ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle CPU
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           mem_we,
   output logic           iord,
   output logic           ir_write,
   output logic           pc_write,
   output logic [1:0]     pc_src,
   output logic           reg_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_op,
   output logic           b_sel_pos,
   output logic           b_sel_neg,
   output logic           alu_cin,
   output logic           illegal,
   output logic           instr_done,
   output logic [STW-1:0] state_dbg
);

   state_t     state_q, state_d;
   iclass_t    cls_q;
   logic [2:0] alu_op_q;
   logic       pos_q, neg_q, cin_q;

   iclass_t    dec_cls;
   logic [2:0] dec_alu_op;
   logic       dec_pos, dec_neg, dec_cin;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode    (opcode),
      .funct     (funct),
      .cls       (dec_cls),
      .alu_op    (dec_alu_op),
      .b_sel_pos (dec_pos),
      .b_sel_neg (dec_neg),
      .alu_cin   (dec_cin)
   );

   // State register; reset forces RST immediately, even mid-instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RST;
      else        state_q <= state_d;
   end

   // Capture the decoded instruction in DECODE so later states ignore opcode/funct
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_q    <= ILL;
         alu_op_q <= ALU_ADD;
         pos_q    <= 1'b1;
         neg_q    <= 1'b0;
         cin_q    <= 1'b0;
      end else if (state_q == DECODE) begin
         cls_q    <= dec_cls;
         alu_op_q <= dec_alu_op;
         pos_q    <= dec_pos;
         neg_q    <= dec_neg;
         cin_q    <= dec_cin;
      end
   end

   // Next-state and datapath controls; everything idles low, true-B selected outside RST
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PCSRC_ALU;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_ADD;
      b_sel_pos  = 1'b1;
      b_sel_neg  = 1'b0;
      alu_cin    = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         RST: begin
            b_sel_pos = 1'b0;
            state_d   = FETCH;
         end
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = PCSRC_ALU;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (dec_cls)
               RTYPE, ADDI, LW, SW: state_d = EXEC;
               BEQ:                 state_d = BRANCH;
               J:                   state_d = JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         EXEC: begin
            alu_src_a = 1'b1;
            b_sel_pos = pos_q;
            b_sel_neg = neg_q;
            alu_cin   = cin_q;
            if (cls_q == RTYPE) begin
               alu_src_b = SRCB_REG;
               alu_op    = alu_op_q;
               state_d   = WB_ALU;
            end else begin
               alu_src_b = SRCB_IMM;
               case (cls_q)
                  ADDI:    state_d = WB_ALU;
                  LW:      state_d = MEM_RD;
                  SW:      state_d = MEM_WR;
                  default: state_d = FETCH;
               endcase
            end
         end
         MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = WB_MEM;
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = FETCH;
            end
         end
         WB_ALU: begin
            reg_write  = 1'b1;
            reg_dst    = (cls_q == RTYPE);
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_REG;
            b_sel_pos  = pos_q;
            b_sel_neg  = neg_q;
            alu_cin    = cin_q;
            pc_src     = PCSRC_ALUOUT;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign state_dbg = STW'(state_q);

endmodule
